// File: rtl/cache_arbiter_if.sv
// Bus bundle between the I-cache/D-cache miss ports, the arbiter and physical memory.
// slave  : the arbiter's view (requests and pmem responses in, strobes and resps out).
// master : the environment's view (caches plus memory).
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              a_read;
    logic [ADDR_W-1:0] a_address;
    logic              mem_resp_a;
    logic [LINE_W-1:0] a_rdata;

    logic              b_read;
    logic              b_write;
    logic [ADDR_W-1:0] b_address;
    logic [LINE_W-1:0] b_wdata;
    logic              mem_resp_b;
    logic [LINE_W-1:0] b_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;

    modport slave (
        input  a_read, a_address, b_read, b_write, b_address, b_wdata,
               pmem_resp, pmem_rdata,
        output mem_resp_a, a_rdata, mem_resp_b, b_rdata,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output a_read, a_address, b_read, b_write, b_address, b_wdata,
               pmem_resp, pmem_rdata,
        input  mem_resp_a, a_rdata, mem_resp_b, b_rdata,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: multiplexes I-cache (port A) and D-cache (port B) line misses onto a
// single physical-memory port, one transaction in flight at a time. The winning
// request is latched at grant so the memory side stays stable until pmem_resp.
// Configuration macro ARB_ROUND_ROBIN_EN: when defined, ties alternate using a
// last_grant register; when undefined, port B always wins ties.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic            clk,
    input  logic            reset,
    cache_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_e;

    state_e            state;
    state_e            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              write_q;

    logic              a_req;
    logic              b_req;
    logic              prefer_b;
    logic              grant_a;
    logic              grant_b;

    assign a_req = bus.a_read;
    assign b_req = bus.b_read | bus.b_write;

`ifdef ARB_ROUND_ROBIN_EN
    typedef enum logic {PORT_A, PORT_B} port_e;
    port_e last_grant;

    // Remember which port won the most recent grant.
    always_ff @(posedge clk) begin
        if (reset)        last_grant <= PORT_A;
        else if (grant_b) last_grant <= PORT_B;
        else if (grant_a) last_grant <= PORT_A;
    end

    assign prefer_b = (last_grant == PORT_A);
`else
    assign prefer_b = 1'b1;
`endif

    // Pick a winner only while IDLE; the loser keeps its level request up and waits.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (b_req && (!a_req || prefer_b)) grant_b = 1'b1;
            else if (a_req)                    grant_a = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: grant from IDLE, return to IDLE on the memory completion.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant_b)      state_next = SERVE_B;
                else if (grant_a) state_next = SERVE_A;
            end
            SERVE_A, SERVE_B: begin
                if (bus.pmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the granted request; on a B read+write the write wins.
    always_ff @(posedge clk) begin
        // NOTE: these datapath registers are reset because pmem_address/pmem_wdata have defined reset values.
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (grant_b) begin
            addr_q  <= bus.b_address;
            wdata_q <= bus.b_wdata;
            write_q <= bus.b_write;
        end else if (grant_a) begin
            addr_q  <= bus.a_address;
            write_q <= 1'b0;
        end
    end

    // Outputs: strobes from the state and latched op, resps straight from pmem_resp.
    always_comb begin
        bus.pmem_read    = (state == SERVE_A) || ((state == SERVE_B) && !write_q);
        bus.pmem_write   = (state == SERVE_B) && write_q;
        bus.pmem_address = addr_q;
        bus.pmem_wdata   = wdata_q;
        bus.mem_resp_a   = (state == SERVE_A) && bus.pmem_resp;
        bus.mem_resp_b   = (state == SERVE_B) && bus.pmem_resp;
        bus.a_rdata      = bus.pmem_rdata;
        bus.b_rdata      = bus.pmem_rdata;
    end
endmodule
